rs_station_param: RTL and testbench

// Parametrised reservation station for the Tomasulo core; the next generation of the fixed
// 3-entry ADD/MUL stations. Holds DEPTH issued instructions and snoops the CDB to wake up

---
 rtl/rs_station_param_pkg.sv | 20 ++
 rtl/rs_station_param_age_matrix.sv | 50 +++++
 rtl/rs_station_param.sv | 174 +++++++++++++++++
 tb/tb_rs_station_param.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rs_station_param_pkg.sv
// Shared definitions for the parametrised reservation station: tag encoding,
// default widths and opcode encodings.
package rs_station_param_pkg;

    localparam int unsigned TAG_NONE     = 0;

    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_TAG_W    = 3;
    localparam int unsigned DEF_DEPTH    = 4;
    localparam int unsigned DEF_OPC_W    = 2;
    localparam int unsigned DEF_BASE_TAG = 1;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } rs_op_e;

endpackage

// File: rtl/rs_station_param_age_matrix.sv
// DEPTH x DEPTH age matrix: older_q[j][i] set means entry j was allocated before entry i.
// Reports the oldest entry among a request mask.
module rs_age_matrix #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_i,
    input  logic [$clog2(DEPTH)-1:0]   alloc_idx_i,
    input  logic [DEPTH-1:0]           req_i,
    output logic                       any_o,
    output logic [$clog2(DEPTH)-1:0]   grant_idx_o
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
    logic                        blocked;

    // A new entry is younger than everything; stale bits of free entries are masked by req_i.
    always_comb begin
        older_d = older_q;
        if (alloc_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                older_d[alloc_idx_i][i] = 1'b0;
                older_d[i][alloc_idx_i] = (IDX_W'(i) != alloc_idx_i);
            end
        end
    end

    always_comb begin
        any_o       = |req_i;
        grant_idx_o = '0;
        blocked     = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (req_i[i]) begin
                blocked = 1'b0;
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    if (req_i[j] && older_q[j][i]) blocked = 1'b1;
                end
                if (!blocked) grant_idx_o = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) older_q <= '0;
        else     older_q <= older_d;
    end

endmodule

// File: rtl/rs_station_param.sv
// Parametrised reservation station: DEPTH entries with CDB snoop/bypass wakeup and
// oldest-ready dispatch over a valid/ready handshake that locks while stalled.
module rs_station_param
    import rs_station_param_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned TAG_W    = DEF_TAG_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned OPC_W    = DEF_OPC_W,
    parameter int unsigned BASE_TAG = DEF_BASE_TAG
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [OPC_W-1:0]             issue_op,
    input  logic [DATA_W-1:0]            issue_vj,
    input  logic [TAG_W-1:0]             issue_qj,
    input  logic [DATA_W-1:0]            issue_vk,
    input  logic [TAG_W-1:0]             issue_qk,
    output logic [TAG_W-1:0]             issue_tag,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [DATA_W-1:0]            cdb_data,
    output logic                         disp_valid,
    input  logic                         disp_ready,
    output logic [OPC_W-1:0]             disp_op,
    output logic [DATA_W-1:0]            disp_vj,
    output logic [DATA_W-1:0]            disp_vk,
    output logic [TAG_W-1:0]             disp_tag,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [OPC_W-1:0]  op_q [DEPTH];
    logic [OPC_W-1:0]  op_d [DEPTH];
    logic [DATA_W-1:0] vj_q [DEPTH];
    logic [DATA_W-1:0] vj_d [DEPTH];
    logic [DATA_W-1:0] vk_q [DEPTH];
    logic [DATA_W-1:0] vk_d [DEPTH];
    logic [TAG_W-1:0]  qj_q [DEPTH];
    logic [TAG_W-1:0]  qj_d [DEPTH];
    logic [TAG_W-1:0]  qk_q [DEPTH];
    logic [TAG_W-1:0]  qk_d [DEPTH];
    logic              lock_q, lock_d;
    logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;

    logic [IDX_W-1:0]  free_idx, grant_idx, sel_idx;
    logic              free_found, any_ready;
    logic [DEPTH-1:0]  ready;
    logic [CNT_W-1:0]  cnt;
    logic              cdb_hit, issue_fire, disp_fire;

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        cnt        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!busy_q[i] && !free_found) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
            cnt      = cnt + CNT_W'(busy_q[i]);
            ready[i] = busy_q[i] && (qj_q[i] == TAG_W'(TAG_NONE)) && (qk_q[i] == TAG_W'(TAG_NONE));
        end
    end

    assign count       = cnt;
    assign full        = (cnt == CNT_W'(DEPTH));
    assign empty       = (cnt == '0);
    assign issue_ready = !full;
    assign issue_tag   = TAG_W'(BASE_TAG) + TAG_W'(free_idx);

    rs_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk         (clk),
        .rst         (rst),
        .alloc_i     (issue_fire),
        .alloc_idx_i (free_idx),
        .req_i       (ready),
        .any_o       (any_ready),
        .grant_idx_o (grant_idx)
    );

    // A stalled presentation is pinned to its entry so an older wakeup cannot swap it.
    assign sel_idx    = lock_q ? lock_idx_q : grant_idx;
    assign disp_valid = lock_q || any_ready;
    assign disp_op    = disp_valid ? op_q[sel_idx] : '0;
    assign disp_vj    = disp_valid ? vj_q[sel_idx] : '0;
    assign disp_vk    = disp_valid ? vk_q[sel_idx] : '0;
    assign disp_tag   = disp_valid ? (TAG_W'(BASE_TAG) + TAG_W'(sel_idx)) : '0;

    assign cdb_hit    = cdb_valid && (cdb_tag != TAG_W'(TAG_NONE));
    assign issue_fire = issue_valid && !full && !flush;
    assign disp_fire  = disp_valid && disp_ready && !flush;

    always_comb begin
        busy_d     = busy_q;
        op_d       = op_q;
        vj_d       = vj_q;
        vk_d       = vk_q;
        qj_d       = qj_q;
        qk_d       = qk_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (flush) begin
            busy_d = '0;
            lock_d = 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (busy_q[i] && cdb_hit && qj_q[i] == cdb_tag) begin
                    vj_d[i] = cdb_data;
                    qj_d[i] = TAG_W'(TAG_NONE);
                end
                if (busy_q[i] && cdb_hit && qk_q[i] == cdb_tag) begin
                    vk_d[i] = cdb_data;
                    qk_d[i] = TAG_W'(TAG_NONE);
                end
            end
            if (disp_fire) begin
                busy_d[sel_idx] = 1'b0;
                lock_d          = 1'b0;
            end else if (disp_valid) begin
                lock_d     = 1'b1;
                lock_idx_d = sel_idx;
            end
            if (issue_fire) begin
                busy_d[free_idx] = 1'b1;
                op_d[free_idx]   = issue_op;
                if (cdb_hit && issue_qj == cdb_tag) begin
                    vj_d[free_idx] = cdb_data;
                    qj_d[free_idx] = TAG_W'(TAG_NONE);
                end else begin
                    vj_d[free_idx] = issue_vj;
                    qj_d[free_idx] = issue_qj;
                end
                if (cdb_hit && issue_qk == cdb_tag) begin
                    vk_d[free_idx] = cdb_data;
                    qk_d[free_idx] = TAG_W'(TAG_NONE);
                end else begin
                    vk_d[free_idx] = issue_vk;
                    qk_d[free_idx] = issue_qk;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            op_q       <= '{default: '0};
            vj_q       <= '{default: '0};
            vk_q       <= '{default: '0};
            qj_q       <= '{default: '0};
            qk_q       <= '{default: '0};
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            busy_q     <= busy_d;
            op_q       <= op_d;
            vj_q       <= vj_d;
            vk_q       <= vk_d;
            qj_q       <= qj_d;
            qk_q       <= qk_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: tb/tb_rs_station_param.sv
// Directed self-checking bench for rs_station_param (DEPTH=4, BASE_TAG=1).
module tb_rs_station_param;
    import rs_station_param_pkg::*;

    logic       clk = 1'b0;
    logic       rst, flush;
    logic       issue_valid, issue_ready;
    logic [1:0] issue_op;
    logic [7:0] issue_vj, issue_vk;
    logic [2:0] issue_qj, issue_qk, issue_tag;
    logic       cdb_valid;
    logic [2:0] cdb_tag;
    logic [7:0] cdb_data;
    logic       disp_valid, disp_ready;
    logic [1:0] disp_op;
    logic [7:0] disp_vj, disp_vk;
    logic [2:0] disp_tag;
    logic [2:0] count;
    logic       full, empty;

    int n_checks = 0;
    int n_fail   = 0;

    rs_station_param #(
        .DATA_W(8), .TAG_W(3), .DEPTH(4), .OPC_W(2), .BASE_TAG(1)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_vj(issue_vj), .issue_qj(issue_qj), .issue_vk(issue_vk), .issue_qk(issue_qk),
        .issue_tag(issue_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_tag(disp_tag),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic [1:0] op, input logic [7:0] vj, input logic [2:0] qj,
                             input logic [7:0] vk, input logic [2:0] qk);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_vj    = vj;
        issue_qj    = qj;
        issue_vk    = vk;
        issue_qk    = qk;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_op = '0;
        issue_vj = '0; issue_qj = '0; issue_vk = '0; issue_qk = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; disp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_status: empty=%0b full=%0b expected 1/0", empty, full); end
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready: got %0b expected 1", issue_ready); end
        n_checks++; if (disp_valid !== 1'b0 || disp_vj !== 8'h00 || disp_tag !== 3'd0) begin n_fail++; $display("FAIL reset_disp: valid=%0b vj=%0h tag=%0d expected 0/0/0", disp_valid, disp_vj, disp_tag); end
        n_checks++; if (issue_tag !== 3'd1) begin n_fail++; $display("FAIL reset_issue_tag: got %0d expected 1", issue_tag); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        disp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_issue(OP_ADD, 8'(k), 3'd0, 8'h00, 3'd0);
            n_checks++; if (issue_tag !== 3'(k + 1)) begin n_fail++; $display("FAIL fill_tag%0d: got %0d expected %0d", k, issue_tag, k + 1); end
            tick();
        end
        n_checks++; if (full !== 1'b1 || issue_ready !== 1'b0 || count !== 3'd4) begin n_fail++; $display("FAIL fill_full: full=%0b ready=%0b count=%0d expected 1/0/4", full, issue_ready, count); end
        tick();
        issue_valid = 1'b0;
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_stall: count=%0d expected 4", count); end
        n_checks++; if (disp_tag !== 3'd1 || disp_vj !== 8'h00) begin n_fail++; $display("FAIL fill_oldest: tag=%0d vj=%0h expected 1/00", disp_tag, disp_vj); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if (empty !== 1'b1 || count !== 3'd0 || disp_valid !== 1'b0) begin n_fail++; $display("FAIL fill_flush: empty=%0b count=%0d dv=%0b expected 1/0/0", empty, count, disp_valid); end
    endtask

    task automatic test_wakeup();
        set_issue(OP_MUL, 8'h00, 3'd5, 8'h03, 3'd0);
        n_checks++; if (issue_tag !== 3'd1) begin n_fail++; $display("FAIL wake_issue_tag: got %0d expected 1", issue_tag); end
        tick();
        issue_valid = 1'b0;
        n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL wake_pending: disp_valid=%0b expected 0", disp_valid); end
        cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 8'h22;
        #1;
        n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL wake_same_cycle: disp_valid=%0b expected 0", disp_valid); end
        tick();
        cdb_valid = 1'b0;
        n_checks++; if (disp_valid !== 1'b1 || disp_vj !== 8'h22 || disp_vk !== 8'h03 || disp_tag !== 3'd1 || disp_op !== OP_MUL) begin
            n_fail++; $display("FAIL wake_disp: v=%0b vj=%0h vk=%0h tag=%0d op=%0d expected 1/22/03/1/2", disp_valid, disp_vj, disp_vk, disp_tag, disp_op);
        end
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;
        n_checks++; if (empty !== 1'b1 || disp_valid !== 1'b0) begin n_fail++; $display("FAIL wake_drain: empty=%0b dv=%0b expected 1/0", empty, disp_valid); end
    endtask

    task automatic test_bypass();
        set_issue(OP_SUB, 8'h11, 3'd0, 8'h99, 3'd6);
        cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 8'h7F;
        #1;
        n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_no_same_cycle: dv=%0b expected 0", disp_valid); end
        tick();
        issue_valid = 1'b0; cdb_valid = 1'b0;
        n_checks++; if (disp_valid !== 1'b1 || disp_vk !== 8'h7F || disp_vj !== 8'h11 || disp_tag !== 3'd1) begin
            n_fail++; $display("FAIL bypass_disp: v=%0b vj=%0h vk=%0h tag=%0d expected 1/11/7f/1", disp_valid, disp_vj, disp_vk, disp_tag);
        end
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL bypass_drain: empty=%0b expected 1", empty); end
    endtask

    task automatic test_age_lock();
        disp_ready = 1'b0;
        set_issue(OP_ADD, 8'h00, 3'd7, 8'h01, 3'd0);
        tick();
        set_issue(OP_ADD, 8'h33, 3'd0, 8'h02, 3'd0);
        tick();
        issue_valid = 1'b0;
        n_checks++; if (disp_valid !== 1'b1 || disp_tag !== 3'd2) begin n_fail++; $display("FAIL age_first: v=%0b tag=%0d expected 1/2", disp_valid, disp_tag); end
        cdb_valid = 1'b1; cdb_tag = 3'd7; cdb_data = 8'h44;
        tick();
        cdb_valid = 1'b0;
        n_checks++; if (disp_tag !== 3'd2 || disp_vj !== 8'h33) begin n_fail++; $display("FAIL lock_hold: tag=%0d vj=%0h expected 2/33", disp_tag, disp_vj); end
        tick();
        n_checks++; if (disp_tag !== 3'd2) begin n_fail++; $display("FAIL lock_hold2: tag=%0d expected 2", disp_tag); end
        disp_ready = 1'b1;
        tick();
        n_checks++; if (disp_tag !== 3'd1 || disp_vj !== 8'h44 || count !== 3'd1) begin n_fail++; $display("FAIL lock_release: tag=%0d vj=%0h count=%0d expected 1/44/1", disp_tag, disp_vj, count); end
        tick();
        disp_ready = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL age_drain: empty=%0b expected 1", empty); end
    endtask

    task automatic test_back_to_back();
        disp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_issue(OP_ADD, 8'(8'h10 + k), 3'd0, 8'h00, 3'd0);
            tick();
        end
        set_issue(OP_DIV, 8'h55, 3'd0, 8'h00, 3'd0);
        disp_ready = 1'b1;
        n_checks++; if (issue_ready !== 1'b0 || disp_tag !== 3'd1) begin n_fail++; $display("FAIL simul_pre: ready=%0b tag=%0d expected 0/1", issue_ready, disp_tag); end
        tick();
        n_checks++; if (count !== 3'd3 || issue_ready !== 1'b1 || issue_tag !== 3'd1 || disp_tag !== 3'd2) begin
            n_fail++; $display("FAIL simul_stall: count=%0d ready=%0b itag=%0d dtag=%0d expected 3/1/1/2", count, issue_ready, issue_tag, disp_tag);
        end
        tick();
        issue_valid = 1'b0; disp_ready = 1'b0;
        n_checks++; if (count !== 3'd3 || disp_tag !== 3'd3 || disp_vj !== 8'h12) begin
            n_fail++; $display("FAIL simul_age: count=%0d tag=%0d vj=%0h expected 3/3/12", count, disp_tag, disp_vj);
        end
        flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 8'hEE;
        tick();
        flush = 1'b0; cdb_valid = 1'b0;
        n_checks++; if (empty !== 1'b1 || count !== 3'd0 || disp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clear: empty=%0b count=%0d dv=%0b expected 1/0/0", empty, count, disp_valid); end
        set_issue(OP_ADD, 8'h01, 3'd0, 8'h02, 3'd0);
        tick();
        issue_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 8'hEE;
        tick();
        cdb_valid = 1'b0;
        n_checks++; if (disp_valid !== 1'b1 || disp_vj !== 8'h01 || disp_vk !== 8'h02) begin n_fail++; $display("FAIL cdb_tag0: v=%0b vj=%0h vk=%0h expected 1/01/02", disp_valid, disp_vj, disp_vk); end
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        disp_ready = 1'b0;
        set_issue(OP_ADD, 8'h05, 3'd0, 8'h06, 3'd0);
        tick();
        tick();
        issue_valid = 1'b0;
        n_checks++; if (count !== 3'd2 || disp_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: count=%0d dv=%0b expected 2/1", count, disp_valid); end
        disp_ready = 1'b1;
        rst = 1'b1;
        #1;
        n_checks++; if (count !== 3'd0 || disp_valid !== 1'b0 || issue_tag !== 3'd1) begin
            n_fail++; $display("FAIL midrst: count=%0d dv=%0b itag=%0d expected 0/0/1", count, disp_valid, issue_tag);
        end
        tick();
        rst = 1'b0; disp_ready = 1'b0;
        tick();
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL midrst_after: empty=%0b expected 1", empty); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wakeup();
        test_bypass();
        test_age_lock();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
